apb_requester_arbiter: RTL and testbench

- Shares the single APB requester port among NUM_REQ independent command sources (test sequencers, DMA-style agents).
- Arbitrates between them round-robin and sequences the SETUP/ACCESS protocol on the APB bus.
- Enforces word alignment and bounds pready wait-states with a timeout.
- Returns read data and error status to the granted requester as a one-cycle response pulse.

---
 rtl/apb_requester_arbiter_if.sv | 47 ++++
 rtl/apb_requester_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_apb_requester_arbiter.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_requester_arbiter_if.sv
// Bundle of requester command/response signals and the APB requester bus.
// Handshake: a requester holds req_valid and its req_* fields until it
// observes its req_ready bit; req_ready and rsp_valid are one-cycle pulses.
// The "master" modport is the arbiter side; "slave" is the requester and
// completer side.
interface apb_requester_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_write;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ*STRB_WIDTH-1:0] req_strb;
  logic [NUM_REQ*3-1:0]          req_prot;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_rdata;
  logic                          rsp_slverr;
  logic                          rsp_timeout;
  logic                          psel;
  logic                          penable;
  logic                          pwrite;
  logic [ADDR_WIDTH-1:0]         paddr;
  logic [DATA_WIDTH-1:0]         pwdata;
  logic [STRB_WIDTH-1:0]         pstrb;
  logic [2:0]                    pprot;
  logic                          pready;
  logic                          pslverr;
  logic [DATA_WIDTH-1:0]         prdata;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_strb, req_prot,
    input  pready, pslverr, prdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
    output psel, penable, pwrite, paddr, pwdata, pstrb, pprot
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_strb, req_prot,
    output pready, pslverr, prdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
    input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot
  );
endinterface

// File: rtl/apb_requester_arbiter.sv
// Round-robin arbiter that shares one APB requester port among NUM_REQ
// command sources. One transfer in flight; all outputs are registers.
// Timeline per transfer: accept (req_ready) -> SETUP -> ACCESS(+waits) -> RESP.
module apb_requester_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int STRB_WIDTH     = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    pclk,
  input  logic                    preset,
  apb_requester_arbiter_if.master bus,
  output logic [1:0]              dbg_state
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t                 state_q, state_d;
  logic [GW-1:0]          last_q, last_d, gnt_q, gnt_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [NUM_REQ-1:0]     req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic                   slverr_q, slverr_d, timeout_q, timeout_d;
  logic                   psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0]  paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0]  pwdata_q, pwdata_d;
  logic [STRB_WIDTH-1:0]  pstrb_q, pstrb_d;
  logic [2:0]             pprot_q, pprot_d;
  logic                   found;
  logic [GW-1:0]          pick;

  function automatic logic [GW-1:0] rr_idx(input logic [GW-1:0] base, input int off);
    int s;
    s = (int'(base) + off) % NUM_REQ;
    return GW'(s);
  endfunction

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    found = 1'b0;
    pick  = last_q;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!found && bus.req_valid[rr_idx(last_q, i)]) begin
        found = 1'b1;
        pick  = rr_idx(last_q, i);
      end
    end
  end

  // Next-state and next-output logic; the accept cycle is IDLE with req_ready set.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    gnt_d       = gnt_q;
    cnt_d       = cnt_q;
    req_ready_d = '0;
    rsp_valid_d = '0;
    rdata_d     = rdata_q;
    slverr_d    = slverr_q;
    timeout_d   = timeout_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    pprot_d     = pprot_q;
    case (state_q)
      IDLE: begin
        if (|req_ready_q) begin
          if (paddr_q[1:0] != 2'b00) begin
            state_d            = RESP;
            rsp_valid_d[gnt_q] = 1'b1;
            rdata_d            = '0;
            slverr_d           = 1'b1;
            timeout_d          = 1'b0;
          end else begin
            state_d = SETUP;
            psel_d  = 1'b1;
          end
        end else if (found) begin
          req_ready_d[pick] = 1'b1;
          gnt_d             = pick;
          last_d            = pick;
          pwrite_d          = bus.req_write[pick];
          paddr_d           = bus.req_addr[int'(pick)*ADDR_WIDTH +: ADDR_WIDTH];
          pwdata_d          = bus.req_wdata[int'(pick)*DATA_WIDTH +: DATA_WIDTH];
          pstrb_d           = bus.req_write[pick] ?
                              bus.req_strb[int'(pick)*STRB_WIDTH +: STRB_WIDTH] : '0;
          pprot_d           = bus.req_prot[int'(pick)*3 +: 3];
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (bus.pready) begin
          state_d            = RESP;
          psel_d             = 1'b0;
          penable_d          = 1'b0;
          rsp_valid_d[gnt_q] = 1'b1;
          rdata_d            = pwrite_q ? '0 : bus.prdata;
          slverr_d           = bus.pslverr;
          timeout_d          = 1'b0;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          state_d            = RESP;
          psel_d             = 1'b0;
          penable_d          = 1'b0;
          rsp_valid_d[gnt_q] = 1'b1;
          rdata_d            = '0;
          slverr_d           = 1'b1;
          timeout_d          = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset drops the bus and rewinds the pointer.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q     <= IDLE;
      last_q      <= GW'(NUM_REQ - 1);
      gnt_q       <= '0;
      cnt_q       <= '0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rdata_q     <= '0;
      slverr_q    <= 1'b0;
      timeout_q   <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      pprot_q     <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      gnt_q       <= gnt_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      slverr_q    <= slverr_d;
      timeout_q   <= timeout_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      pprot_q     <= pprot_d;
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rdata_q;
  assign bus.rsp_slverr  = slverr_q;
  assign bus.rsp_timeout = timeout_q;
  assign bus.psel        = psel_q;
  assign bus.penable     = penable_q;
  assign bus.pwrite      = pwrite_q;
  assign bus.paddr       = paddr_q;
  assign bus.pwdata      = pwdata_q;
  assign bus.pstrb       = pstrb_q;
  assign bus.pprot       = pprot_q;
  assign dbg_state       = state_q;
endmodule

// File: tb/tb_apb_requester_arbiter.sv
// Directed bench for apb_requester_arbiter: a vector table of single
// transfers plus hand-written contention and mid-transfer reset sequences.
module tb_apb_requester_arbiter;
  localparam int NR = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;

  logic       pclk;
  logic       preset;
  logic [1:0] dbg_state;

  apb_requester_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW)) bus ();

  apb_requester_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW), .TIMEOUT_CYCLES(16)
  ) dut (
    .pclk(pclk),
    .preset(preset),
    .bus(bus),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // completer model: waits cfg_wait ACCESS cycles, or never answers when cfg_hang
  int          cfg_wait = 0;
  logic        cfg_hang = 1'b0;
  logic [31:0] cfg_prdata = '0;
  logic        cfg_perr = 1'b0;
  int          acc_cnt = 0;

  always @(negedge pclk) begin
    if (bus.psel && bus.penable) begin
      bus.pready = (!cfg_hang && acc_cnt == cfg_wait);
      acc_cnt++;
    end else begin
      bus.pready = 1'b0;
      acc_cnt = 0;
    end
    bus.prdata  = cfg_prdata;
    bus.pslverr = cfg_perr;
  end

  typedef struct {
    int          id;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    int          wait_n;
    logic        hang;
    logic [31:0] prdata;
    logic        perr;
    int          exp_lat;
    logic        exp_psel;
    logic [3:0]  exp_pstrb;
    logic        chk_rdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_to;
  } vec_t;

  vec_t vecs[9];

  // driver tasks
  task automatic drive_req(input int id, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] strb, input logic [2:0] prot);
    bus.req_write[id]          = wr;
    bus.req_addr[id*AW +: AW]  = addr;
    bus.req_wdata[id*DW +: DW] = wdata;
    bus.req_strb[id*SW +: SW]  = strb;
    bus.req_prot[id*3 +: 3]    = prot;
  endtask

  task automatic wait_ready(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge pclk);
      if (|bus.req_ready) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_rsp(output logic ok, output int lat);
    ok  = 1'b0;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge pclk);
      if (|bus.rsp_valid) begin
        ok  = 1'b1;
        lat = i;
        break;
      end
    end
  endtask

  task automatic run_vec(input int n, input vec_t v);
    logic ok, got, seen_psel;
    int   lat;
    logic [NR-1:0] oh;
    oh = '0;
    oh[v.id] = 1'b1;
    @(negedge pclk);
    cfg_wait   = v.wait_n;
    cfg_hang   = v.hang;
    cfg_prdata = v.prdata;
    cfg_perr   = v.perr;
    drive_req(v.id, v.wr, v.addr, v.wdata, v.strb, v.prot);
    bus.req_valid = oh;
    wait_ready(ok);
    check($sformatf("v%0d ready_seen", n), 64'(ok), 64'(1));
    check($sformatf("v%0d req_ready", n), 64'(bus.req_ready), 64'(oh));
    bus.req_valid = '0;
    drive_req(v.id, ~v.wr, v.addr ^ 32'h0000_0F00, ~v.wdata, ~v.strb, ~v.prot);
    got = 1'b0;
    lat = 0;
    seen_psel = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge pclk);
      if (bus.psel) seen_psel = 1'b1;
      if (i == 1 && v.exp_psel) begin
        check($sformatf("v%0d setup_psel", n), 64'(bus.psel), 64'(1));
        check($sformatf("v%0d setup_penable", n), 64'(bus.penable), 64'(0));
        check($sformatf("v%0d paddr", n), 64'(bus.paddr), 64'(v.addr));
        check($sformatf("v%0d pwrite", n), 64'(bus.pwrite), 64'(v.wr));
        check($sformatf("v%0d pstrb", n), 64'(bus.pstrb), 64'(v.exp_pstrb));
        check($sformatf("v%0d pprot", n), 64'(bus.pprot), 64'(v.prot));
        if (v.wr) check($sformatf("v%0d pwdata", n), 64'(bus.pwdata), 64'(v.wdata));
      end
      if (i == 2 && v.exp_psel) begin
        check($sformatf("v%0d access_penable", n), 64'(bus.penable), 64'(1));
        check($sformatf("v%0d access_paddr", n), 64'(bus.paddr), 64'(v.addr));
      end
      if (|bus.rsp_valid) begin
        got = 1'b1;
        lat = i;
        break;
      end
    end
    check($sformatf("v%0d rsp_seen", n), 64'(got), 64'(1));
    check($sformatf("v%0d latency", n), 64'(lat), 64'(v.exp_lat));
    check($sformatf("v%0d rsp_valid", n), 64'(bus.rsp_valid), 64'(oh));
    check($sformatf("v%0d slverr", n), 64'(bus.rsp_slverr), 64'(v.exp_err));
    check($sformatf("v%0d timeout", n), 64'(bus.rsp_timeout), 64'(v.exp_to));
    if (v.chk_rdata) check($sformatf("v%0d rdata", n), 64'(bus.rsp_rdata), 64'(v.exp_rdata));
    check($sformatf("v%0d rsp_psel", n), 64'({bus.psel, bus.penable}), 64'(0));
    check($sformatf("v%0d psel_seen", n), 64'(seen_psel), 64'(v.exp_psel));
    @(negedge pclk);
    check($sformatf("v%0d rsp_pulse", n), 64'(bus.rsp_valid), 64'(0));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " req_ready"}, 64'(bus.req_ready), 64'(0));
    check({tag, " rsp_valid"}, 64'(bus.rsp_valid), 64'(0));
    check({tag, " rsp_rdata"}, 64'(bus.rsp_rdata), 64'(0));
    check({tag, " rsp_flags"}, 64'({bus.rsp_slverr, bus.rsp_timeout}), 64'(0));
    check({tag, " psel_penable"}, 64'({bus.psel, bus.penable, bus.pwrite}), 64'(0));
    check({tag, " paddr"}, 64'(bus.paddr), 64'(0));
    check({tag, " pwdata"}, 64'(bus.pwdata), 64'(0));
    check({tag, " pstrb_pprot"}, 64'({bus.pstrb, bus.pprot}), 64'(0));
    check({tag, " state"}, 64'(dbg_state), 64'(0));
  endtask

  // stimulus and checking
  initial begin
    logic ok, any_rsp;
    int   lat;
    logic [NR-1:0] exp_g;

    vecs[0] = '{0, 1'b0, 32'h4,         32'h0,         4'hF, 3'd0, 0, 1'b0, 32'hA5A5_0001, 1'b0,  3, 1'b1, 4'h0, 1'b1, 32'hA5A5_0001, 1'b0, 1'b0};
    vecs[1] = '{1, 1'b1, 32'h84,        32'hFFFF_FFFF, 4'h1, 3'd2, 0, 1'b0, 32'h5555_5555, 1'b0,  3, 1'b1, 4'h1, 1'b1, 32'h0,         1'b0, 1'b0};
    vecs[2] = '{1, 1'b0, 32'h88,        32'h1111_2222, 4'hF, 3'd1, 0, 1'b0, 32'h1234_5678, 1'b0,  3, 1'b1, 4'h0, 1'b1, 32'h1234_5678, 1'b0, 1'b0};
    vecs[3] = '{0, 1'b0, 32'h3,         32'h0,         4'hF, 3'd0, 0, 1'b0, 32'h9999_9999, 1'b0,  1, 1'b0, 4'h0, 1'b0, 32'h0,         1'b1, 1'b0};
    vecs[4] = '{0, 1'b0, 32'h10,        32'h0,         4'h0, 3'd7, 3, 1'b0, 32'hDEAD_BEEF, 1'b0,  6, 1'b1, 4'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0};
    vecs[5] = '{1, 1'b1, 32'h20,        32'hCAFE_F00D, 4'hC, 3'd4, 1, 1'b0, 32'h0,         1'b1,  4, 1'b1, 4'hC, 1'b1, 32'h0,         1'b1, 1'b0};
    vecs[6] = '{0, 1'b0, 32'h30,        32'h0,         4'hF, 3'd0, 0, 1'b1, 32'h7777_7777, 1'b0, 18, 1'b1, 4'h0, 1'b0, 32'h0,         1'b1, 1'b1};
    vecs[7] = '{1, 1'b0, 32'h102,       32'h0,         4'h0, 3'd0, 0, 1'b0, 32'h0,         1'b0,  1, 1'b0, 4'h0, 1'b0, 32'h0,         1'b1, 1'b0};
    vecs[8] = '{0, 1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0, 3'd3, 0, 1'b0, 32'h0BAD_F00D, 1'b1,  3, 1'b1, 4'h0, 1'b1, 32'h0BAD_F00D, 1'b1, 1'b0};

    preset        = 1'b1;
    bus.req_valid = '0;
    bus.req_write = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_strb  = '0;
    bus.req_prot  = '0;
    repeat (3) @(negedge pclk);
    check_reset_state("reset");
    preset = 1'b0;

    for (int n = 0; n < 9; n++) run_vec(n, vecs[n]);

    // contention: both requesters held valid, grants alternate from 0
    @(negedge pclk);
    preset = 1'b1;
    @(negedge pclk);
    preset = 1'b0;
    cfg_wait = 0; cfg_hang = 1'b0; cfg_perr = 1'b0; cfg_prdata = 32'h0000_00AA;
    drive_req(0, 1'b0, 32'h40, 32'h0, 4'h0, 3'd0);
    drive_req(1, 1'b0, 32'h44, 32'h0, 4'h0, 3'd0);
    bus.req_valid = 2'b11;
    for (int t = 0; t < 4; t++) begin
      exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
      wait_ready(ok);
      check($sformatf("rr%0d ready_seen", t), 64'(ok), 64'(1));
      check($sformatf("rr%0d grant", t), 64'(bus.req_ready), 64'(exp_g));
      wait_rsp(ok, lat);
      check($sformatf("rr%0d rsp_valid", t), 64'(bus.rsp_valid), 64'(exp_g));
      check($sformatf("rr%0d latency", t), 64'(lat), 64'(3));
      check($sformatf("rr%0d rdata", t), 64'(bus.rsp_rdata), 64'(32'h0000_00AA));
    end
    bus.req_valid = '0;
    repeat (2) @(negedge pclk);

    // reset during a stalled ACCESS
    cfg_hang = 1'b1;
    bus.req_valid = 2'b10;
    wait_ready(ok);
    check("rst grant1", 64'(bus.req_ready), 64'(2'b10));
    bus.req_valid = '0;
    repeat (4) @(negedge pclk);
    check("rst in_access", 64'({bus.psel, bus.penable}), 64'(2'b11));
    #2 preset = 1'b1;
    #1;
    check("rst async_drop", 64'({bus.psel, bus.penable}), 64'(0));
    any_rsp = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      if (|bus.rsp_valid) any_rsp = 1'b1;
    end
    check("rst no_rsp", 64'(any_rsp), 64'(0));
    check_reset_state("midrst");
    preset   = 1'b0;
    cfg_hang = 1'b0;
    bus.req_valid = 2'b11;
    wait_ready(ok);
    check("rst ready_seen", 64'(ok), 64'(1));
    check("rst next_grant", 64'(bus.req_ready), 64'(2'b01));
    bus.req_valid = '0;
    wait_rsp(ok, lat);
    check("rst rsp_valid", 64'(bus.rsp_valid), 64'(2'b01));
    repeat (2) @(negedge pclk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
